// File: rtl/fetch_align_unit_if.sv
// Fetch-stage bus bundle: program-memory port, redirect and decoder handshake.
// master = fetch unit, slave = memory/decoder side.
interface fetch_align_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  pmReq;
  logic [ADDR_WIDTH-1:0] pmAddr;
  logic                  pmValid;
  logic [31:0]           pmData;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirectPc;
  logic                  insnValid;
  logic                  insnReady;
  logic [31:0]           insn;
  logic [ADDR_WIDTH-1:0] insnPc;
  logic                  insnCompressed;

  modport master (
    output pmReq, pmAddr,
    input  pmValid, pmData,
    input  redirect, redirectPc,
    output insnValid, insn, insnPc, insnCompressed,
    input  insnReady
  );

  modport slave (
    input  pmReq, pmAddr,
    output pmValid, pmData,
    output redirect, redirectPc,
    input  insnValid, insn, insnPc, insnCompressed,
    output insnReady
  );
endinterface

// File: rtl/fetch_align_unit.sv
// Fetch stage: word prefetch FIFO with halfword realignment of
// 16/32-bit rv32imc instructions and redirect flush of in-flight fetches.
module fetch_align_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic arstn,
  fetch_align_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [31:0]   fifoMem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] fifoCount;
  logic [CW-1:0] inFlight;
  logic [CW-1:0] dropCnt;
  addr_t         pmAddrQ;
  addr_t         insnPcQ;
  logic          halfOffset;

  logic [31:0] head;
  logic [15:0] nxtLo;
  logic [15:0] half;
  logic [CW:0] occupancy;
  logic        comp;
  logic        enough;
  logic        req;
  logic        drop;
  logic        push;
  logic        valid;
  logic        fire;
  logic        pop;

  assign head  = fifoMem[rdPtr];
  assign nxtLo = fifoMem[rdPtr + PW'(1)][15:0];
  assign half  = halfOffset ? head[31:16] : head[15:0];
  assign comp  = half[1:0] != 2'b11;

  // A 32-bit insn starting in the upper half also needs the next word.
  assign enough = (halfOffset && !comp) ? (fifoCount >= CW'(2))
                                        : (fifoCount != '0);

  assign occupancy = {1'b0, inFlight} + {1'b0, fifoCount};
  assign req   = arstn && !bus.redirect && (occupancy < DEPTH_V);
  assign drop  = bus.pmValid && (dropCnt != '0);
  assign push  = bus.pmValid && !drop && !bus.redirect;
  assign valid = enough && !bus.redirect;
  assign fire  = valid && bus.insnReady;
  assign pop   = fire && (halfOffset || !comp);

  assign bus.pmReq          = req;
  assign bus.pmAddr         = pmAddrQ;
  assign bus.insnValid      = valid;
  assign bus.insnPc         = insnPcQ;
  assign bus.insnCompressed = enough && comp;
  assign bus.insn = !enough ? 32'h0
                  : comp ? {16'h0, half}
                  : halfOffset ? {nxtLo, half}
                  : head;

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= bus.pmData;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifoCount  <= '0;
      inFlight   <= '0;
      dropCnt    <= '0;
      pmAddrQ    <= RESET_PC & ~addr_t'(3);
      insnPcQ    <= RESET_PC & ~addr_t'(1);
      halfOffset <= RESET_PC[1];
    end else begin
      inFlight <= inFlight + CW'(req) - CW'(bus.pmValid);
      if (req) pmAddrQ <= pmAddrQ + addr_t'(4);
      if (bus.redirect) begin
        // Every request still outstanding after this cycle is stale.
        rdPtr      <= '0;
        wrPtr      <= '0;
        fifoCount  <= '0;
        dropCnt    <= inFlight - CW'(bus.pmValid);
        pmAddrQ    <= bus.redirectPc & ~addr_t'(3);
        insnPcQ    <= bus.redirectPc & ~addr_t'(1);
        halfOffset <= bus.redirectPc[1];
      end else begin
        if (drop) dropCnt <= dropCnt - CW'(1);
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop) rdPtr <= rdPtr + PW'(1);
        fifoCount <= fifoCount + CW'(push) - CW'(pop);
        if (fire) begin
          halfOffset <= halfOffset ^ comp;
          insnPcQ    <= insnPcQ + (comp ? addr_t'(2) : addr_t'(4));
        end
      end
    end
  end

  pmProtocol: assert property (
    @(posedge clk) disable iff (!arstn)
    bus.pmValid |-> (inFlight != '0)
  );
endmodule

// File: tb/tb_fetch_align_unit.sv
// Bench for fetch_align_unit: random memory/latency/ready/redirect stimulus
// against a sequential-PC instruction-stream model, plus directed cases.
module tb_fetch_align_unit;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic arstn = 1'b0;

  fetch_align_unit_if #(.ADDR_WIDTH(AW)) bus();

  fetch_align_unit #(
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .arstn(arstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  logic [31:0] mem [256];
  req_t        pend [$];
  logic [31:0] accPc [$];
  logic [31:0] accInsn [$];
  logic        accComp [$];

  int checks = 0;
  int errors = 0;
  int cyc, curEp, reqCnt, respCnt, staleCnt;
  int latMin, latMax, readyPct, respLimit;
  logic [31:0] expPc, expAddr;
  logic        lastValid, lastReq;
  logic [31:0] lastAddr;
  logic        prevStall;
  logic [31:0] prevInsn, prevPc;
  logic        prevComp;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] half16(logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction at a PC: low halfword decides the length.
  function automatic logic [31:0] insnAt(logic [31:0] a);
    logic [15:0] lo;
    lo = half16(a);
    if (lo[1:0] != 2'b11) return {16'h0, lo};
    return {half16(a + 32'd2), lo};
  endfunction

  task automatic fillNop();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + (i << 12);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic cycle(bit redir, logic [31:0] tgt);
    logic [31:0] e;
    bus.redirect   = redir;
    bus.redirectPc = tgt;
    bus.insnReady  = ($urandom_range(99) < readyPct);
    bus.pmValid    = 1'b0;
    bus.pmData     = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc && respCnt < respLimit) begin
      bus.pmValid = 1'b1;
      bus.pmData  = mem[pend[0].addr[9:2]];
    end
    @(negedge clk);
    if (prevStall && !redir) begin
      check("stallValid", bus.insnValid, 1);
      check("stallInsn", bus.insn, prevInsn);
      check("stallPc", bus.insnPc, prevPc);
      check("stallComp", bus.insnCompressed, prevComp);
    end
    if (bus.pmValid) begin
      if (pend[0].ep != curEp || redir) staleCnt++;
      void'(pend.pop_front());
      respCnt++;
    end
    if (redir) begin
      check("redirReq", bus.pmReq, 0);
      check("redirValid", bus.insnValid, 0);
      expPc   = tgt & ~32'd1;
      expAddr = tgt & ~32'd3;
      curEp++;
    end else begin
      if (bus.pmReq) begin
        check("pmAddr", bus.pmAddr, expAddr);
        pend.push_back('{bus.pmAddr,
                         cyc + int'($urandom_range(latMax, latMin)),
                         curEp});
        expAddr += 32'd4;
        reqCnt++;
        check("inFlightMax", pend.size() <= DEPTH, 1);
      end
      if (bus.insnValid && bus.insnReady) begin
        e = insnAt(expPc);
        check("insnPc", bus.insnPc, expPc);
        check("insn", bus.insn, e);
        check("insnComp", bus.insnCompressed, e[1:0] != 2'b11);
        accPc.push_back(bus.insnPc);
        accInsn.push_back(bus.insn);
        accComp.push_back(bus.insnCompressed);
        expPc += (e[1:0] != 2'b11) ? 32'd2 : 32'd4;
      end
    end
    lastValid = bus.insnValid;
    lastReq   = bus.pmReq;
    lastAddr  = bus.pmAddr;
    prevStall = bus.insnValid && !bus.insnReady && !redir;
    prevInsn  = bus.insn;
    prevPc    = bus.insnPc;
    prevComp  = bus.insnCompressed;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  task automatic doReset();
    arstn          = 1'b0;
    bus.pmValid    = 1'b0;
    bus.pmData     = 32'h0;
    bus.redirect   = 1'b0;
    bus.redirectPc = 32'h0;
    bus.insnReady  = 1'b0;
    pend.delete();
    @(negedge clk);
    check("rstReq", bus.pmReq, 0);
    check("rstAddr", bus.pmAddr, RPC & ~32'd3);
    check("rstValid", bus.insnValid, 0);
    check("rstInsn", bus.insn, 0);
    check("rstPc", bus.insnPc, RPC & ~32'd1);
    check("rstComp", bus.insnCompressed, 0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    accPc.delete();
    accInsn.delete();
    accComp.delete();
    cyc = 0; curEp = 0; reqCnt = 0; respCnt = 0; staleCnt = 0;
    expPc = RPC & ~32'd1;
    expAddr = RPC & ~32'd3;
    prevStall = 1'b0;
    respLimit = 1 << 30;
  endtask

  initial begin
    int n0;
    latMin = 1; latMax = 1; readyPct = 100;

    // 1: 32-bit stream, latency 1
    fillNop();
    doReset();
    run(1);
    check("t1FirstReq", reqCnt, 1);
    run(5);
    check("t1Count", accPc.size(), 4);
    check("t1LastPc", accPc.size() > 0 ? accPc[accPc.size()-1] : 32'hdead, 12);

    // 2: two compressed insns in one word
    fillNop();
    mem[0] = 32'h4501_4505;
    doReset();
    run(5);
    check("t2Count", accPc.size(), 3);
    check("t2Insn0", accPc.size() > 0 ? accInsn[0] : 32'hdead, 32'h4505);
    check("t2Insn1", accPc.size() > 1 ? accInsn[1] : 32'hdead, 32'h4501);
    check("t2Pc1", accPc.size() > 1 ? accPc[1] : 32'hdead, 2);
    check("t2Comp1", accPc.size() > 1 ? accComp[1] : 1'b0, 1);
    check("t2Pc2", accPc.size() > 2 ? accPc[2] : 32'hdead, 4);

    // 3: spanning 32-bit insn waits for the second word
    fillNop();
    mem[0] = 32'h0013_4505;
    mem[1] = 32'h1234_0000;
    doReset();
    respLimit = 1;
    run(6);
    check("t3OnlyOne", accPc.size(), 1);
    check("t3Wait", lastValid, 0);
    respLimit = 1 << 30;
    run(3);
    check("t3Span", accPc.size() > 1 ? accInsn[1] : 32'hdead, 32'h0000_0013);
    check("t3SpanPc", accPc.size() > 1 ? accPc[1] : 32'hdead, 2);
    check("t3SpanComp", accPc.size() > 1 ? accComp[1] : 1'b1, 0);

    // 4: decoder stalled, FIFO fills
    fillRandom();
    doReset();
    readyPct = 0;
    run(10);
    check("t4Reqs", reqCnt, DEPTH);
    check("t4ReqLow", lastReq, 0);
    check("t4NoAccept", accPc.size(), 0);
    readyPct = 100;
    run(8);

    // 5: redirect with three fetches in flight, latency 3
    doReset();
    latMin = 3; latMax = 3;
    run(3);
    cycle(1'b1, 32'h102);
    run(1);
    check("t5Req", lastReq, 1);
    check("t5Addr", lastAddr, 32'h100);
    for (int i = 0; i < 20 && accPc.size() == 0; i++) run(1);
    check("t5Pc", accPc.size() > 0 ? accPc[0] : 32'hdead, 32'h102);
    check("t5Stale", staleCnt, 3);

    // 6: redirect kills a head that would be accepted, then reset mid-fill
    latMin = 1; latMax = 1;
    doReset();
    run(8);
    n0 = accPc.size();
    cycle(1'b1, 32'h200);
    check("t6NoAccept", accPc.size(), n0);
    for (int i = 0; i < 20 && accPc.size() == n0; i++) run(1);
    check("t6Pc", accPc.size() > n0 ? accPc[n0] : 32'hdead, 32'h200);
    run(1);
    doReset();
    run(6);

    // random traffic
    fillRandom();
    latMin = 1; latMax = 4; readyPct = 70;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) cycle(1'b1, 32'($urandom_range(511)) << 1);
      else cycle(1'b0, 32'h0);
    end
    check("progress", accPc.size() > 500, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
